// File: rtl/conv1d_stream_engine_pkg.sv
// conv_pkg: shared types and sizing helpers for conv1d_stream_engine.
//   state_t     - engine FSM states (IDLE, RUN, DRAIN, DONE)
//   acc_width() - signed result width for a given pixel/coef width and tap count
//   padded_len()- length of the (optionally zero-padded) input sequence
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Unsigned pixel widened by one sign bit, times a signed coefficient,
  // summed over taps: log2(taps) growth bits cover the adder tree.
  function automatic int acc_width(input int pix_w, input int coef_w, input int taps);
    return pix_w + coef_w + 1 + $clog2(taps);
  endfunction

  // "same" padding adds (taps-1)/2 zeros on each side; "valid" adds none.
  function automatic int padded_len(input int n_pix, input int taps, input logic pad);
    return pad ? (n_pix + taps - 1) : n_pix;
  endfunction

endpackage

// File: rtl/conv1d_stream_engine_mac_tap.sv
// conv_mac_tap: one registered pixel x coefficient product.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - stage advance; product register holds when low
//   pix        - unsigned pixel
//   coef       - signed coefficient
//   prod       - registered signed product, PIX_W+COEF_W+1 bits
module conv_mac_tap #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic        [PIX_W-1:0]         pix,
  input  logic signed [COEF_W-1:0]        coef,
  output logic signed [PIX_W+COEF_W:0]    prod
);

  localparam int PW = PIX_W + COEF_W + 1;

  // Both operands extended to the full product width so the low PW bits
  // of the multiply are exact: pixel zero-extended, coefficient sign-extended.
  logic signed [PW-1:0] pix_ext;
  logic signed [PW-1:0] coef_ext;

  assign pix_ext  = {{(COEF_W+1){1'b0}}, pix};
  assign coef_ext = {{(PIX_W+1){coef[COEF_W-1]}}, coef};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else if (en) begin
      prod <= pix_ext * coef_ext;
    end
  end

endmodule

// File: rtl/conv1d_stream_engine.sv
// conv1d_stream_engine: captures one pixel row on start and streams its 1-D
// convolution with a runtime-loaded signed kernel.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, pad_en       - row start (IDLE only); "same" padding select
//   row_data            - packed row, pixel i at [i*PIX_W +: PIX_W]
//   coef_we/idx/data    - kernel write port, ignored while busy
//   busy, done          - row in progress; one-cycle completion pulse
//   out_valid/ready     - result handshake
//   out_data, out_idx   - signed result and its output position
//   fsm_state           - current FSM state, for observation
// Handshake: a beat transfers on a rising edge where out_valid && out_ready;
// while out_valid && !out_ready, out_data/out_idx and the whole pipeline hold.
// Build option: define CONV_RELU_EN to clamp negative results to zero.
module conv1d_stream_engine
  import conv_pkg::*;
#(
  parameter  int PIX_W  = 8,
  parameter  int N_PIX  = 32,
  parameter  int TAPS   = 3,
  parameter  int COEF_W = 8,
  localparam int ACC_W  = acc_width(PIX_W, COEF_W, TAPS),
  localparam int CI_W   = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int OI_W   = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      pad_en,
  input  logic [N_PIX*PIX_W-1:0]    row_data,
  input  logic                      coef_we,
  input  logic [CI_W-1:0]           coef_idx,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_data,
  output logic [OI_W-1:0]           out_idx,
  output logic                      done,
  output state_t                    fsm_state
);

  localparam int PAD    = (TAPS - 1) / 2;
  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int CNT_W  = $clog2(N_PIX + TAPS);

  logic [N_PIX*PIX_W-1:0]    row_q;
  logic                      pad_q;
  logic [CNT_W-1:0]          in_cnt;
  logic [PIX_W-1:0]          win [TAPS];
  logic                      win_vld;
  logic                      prod_vld;
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [PROD_W-1:0]  prod [TAPS];
  logic signed [ACC_W-1:0]   sum;
  logic [PIX_W-1:0]          next_pix;
  logic                      advance;
  int                        last_in;
  int                        last_out;

  assign advance  = !out_valid || out_ready;
  assign last_in  = padded_len(N_PIX, TAPS, pad_q) - 1;
  assign last_out = pad_q ? (N_PIX - 1) : (N_PIX - TAPS);

  // Padded-sequence element at in_cnt: row pixel shifted by the left pad,
  // zero outside the row.
  always_comb begin
    next_pix = '0;
    for (int i = 0; i < N_PIX; i++) begin
      if (int'(in_cnt) == i + (pad_q ? PAD : 0)) begin
        next_pix = row_q[i*PIX_W +: PIX_W];
      end
    end
  end

  for (genvar j = 0; j < TAPS; j++) begin : g_tap
    conv_mac_tap #(
      .PIX_W  (PIX_W),
      .COEF_W (COEF_W)
    ) u_tap (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .pix   (win[j]),
      .coef  (coef_q[j]),
      .prod  (prod[j])
    );
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < TAPS; j++) begin
      sum = sum + ACC_W'(prod[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      row_q     <= '0;
      pad_q     <= 1'b0;
      in_cnt    <= '0;
      win_vld   <= 1'b0;
      prod_vld  <= 1'b0;
      for (int j = 0; j < TAPS; j++) begin
        win[j]    <= '0;
        coef_q[j] <= '0;
      end
    end else begin
      // Kernel is frozen for the whole row, including the DONE cycle.
      if (coef_we && !busy && (int'(coef_idx) < TAPS)) begin
        coef_q[coef_idx] <= coef_data;
      end

      case (fsm_state)
        IDLE: begin
          if (start) begin
            fsm_state <= RUN;
            busy      <= 1'b1;
            row_q     <= row_data;
            pad_q     <= pad_en;
            in_cnt    <= '0;
            out_idx   <= '0;
          end
        end
        RUN: begin
          if (advance) begin
            for (int j = 0; j < TAPS - 1; j++) begin
              win[j] <= win[j+1];
            end
            win[TAPS-1] <= next_pix;
            // Window holds a full output once element TAPS-1 has entered.
            win_vld <= (int'(in_cnt) >= TAPS - 1);
            in_cnt  <= in_cnt + 1'b1;
            if (int'(in_cnt) == last_in) begin
              fsm_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (advance) begin
            win_vld <= 1'b0;
          end
          if (out_valid && out_ready && (int'(out_idx) == last_out)) begin
            fsm_state <= DONE;
            done      <= 1'b1;
          end
        end
        DONE: begin
          fsm_state <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
        default: fsm_state <= IDLE;
      endcase

      if (advance) begin
        prod_vld  <= win_vld;
        out_valid <= prod_vld;
`ifdef CONV_RELU_EN
        out_data  <= sum[ACC_W-1] ? '0 : sum;
`else
        out_data  <= sum;
`endif
      end

      // Index stays on the last position after the final beat until next start.
      if (out_valid && out_ready && (int'(out_idx) != last_out)) begin
        out_idx <= out_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_stream_engine.sv
// Self-checking bench for conv1d_stream_engine (default parameters).
module tb_conv1d_stream_engine;
  import conv_pkg::*;

  localparam int PIX_W  = 8;
  localparam int N_PIX  = 32;
  localparam int TAPS   = 3;
  localparam int COEF_W = 8;
  localparam int ACC_W  = PIX_W + COEF_W + 1 + $clog2(TAPS);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic                     start = 1'b0;
  logic                     pad_en = 1'b0;
  logic [N_PIX*PIX_W-1:0]   row_data = '0;
  logic                     coef_we = 1'b0;
  logic [1:0]               coef_idx = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     out_ready = 1'b1;
  logic                     busy, out_valid, done;
  logic signed [ACC_W-1:0]  out_data;
  logic [4:0]               out_idx;
  state_t                   fsm_state;

  conv1d_stream_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pad_en(pad_en),
    .row_data(row_data), .coef_we(coef_we), .coef_idx(coef_idx),
    .coef_data(coef_data), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .done(done), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [ACC_W-1:0] exp_q[$];
  logic [4:0]       exp_idx_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_PIX*PIX_W-1:0] make_row(input bit ramp, input int val);
    logic [N_PIX*PIX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_PIX; i++) r[i*PIX_W +: PIX_W] = PIX_W'(ramp ? i : val);
    return r;
  endfunction

  // Reference: out[k] = sum_j coef[j] * p[k+j], p zero-padded by 1 on each side when pad.
  task automatic push_expected(input logic [N_PIX*PIX_W-1:0] row, input int k0, input int k1,
                               input int k2, input bit pad);
    int kern[3];
    int n_out, lp, acc, idx, px;
    kern[0] = k0; kern[1] = k1; kern[2] = k2;
    n_out = pad ? N_PIX : N_PIX - TAPS + 1;
    lp    = pad ? 1 : 0;
    for (int k = 0; k < n_out; k++) begin
      acc = 0;
      for (int j = 0; j < 3; j++) begin
        idx = k + j - lp;
        px  = (idx < 0 || idx >= N_PIX) ? 0 : int'(row[idx*PIX_W +: PIX_W]);
        acc += kern[j] * px;
      end
`ifdef CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      exp_q.push_back(ACC_W'(acc));
      exp_idx_q.push_back(5'(k));
    end
  endtask

  int first_valid_cyc = -1;
  int beats = 0;
  int first_data = 0;
  int last_data = 0;
  logic [ACC_W-1:0] mon_e;
  logic [4:0]       mon_ei;

  // Sampled mid-low-phase: DUT outputs settled, out_ready already driven for the next edge.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual idx=%0d data=%0d required no beat", out_idx, out_data);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ei = exp_idx_q.pop_front();
        check("beat_data", longint'(out_data), longint'($signed(mon_e)));
        check("beat_idx", longint'(out_idx), longint'(mon_ei));
      end
      if (out_idx == 0) first_data = int'(out_data);
      last_data = int'(out_data);
      beats++;
    end
  end

  // ---------------- driver tasks ----------------
  // Last coefficient write shares its cycle with start.
  task automatic start_row(input logic [N_PIX*PIX_W-1:0] row, input int k0, input int k1,
                           input int k2, input bit pad, input bit load, output int s);
    if (load) begin
      @(negedge clk); coef_we = 1'b1; coef_idx = 2'd0; coef_data = 8'(k0);
      @(negedge clk); coef_idx = 2'd1; coef_data = 8'(k1);
      @(negedge clk); coef_idx = 2'd2; coef_data = 8'(k2);
    end else begin
      @(negedge clk);
    end
    start = 1'b1; pad_en = pad; row_data = row; s = cyc;
    first_valid_cyc = -1; beats = 0; first_data = 0; last_data = 0;
    push_expected(row, k0, k1, k2, pad);
    @(negedge clk);
    start = 1'b0; coef_we = 1'b0;
    check("busy_after_start", longint'(busy), 1);
    // Kernel write and restart while busy must both be ignored.
    coef_we = 1'b1; coef_idx = 2'd0; coef_data = 8'sd100;
    start = 1'b1; row_data = ~row; pad_en = ~pad;
    @(negedge clk);
    coef_we = 1'b0; start = 1'b0;
  endtask

  task automatic wait_row(input int s, input int exp_lat, input int stall_at, input int exp_first,
                          input int exp_last, input int exp_n, input string tag);
    bit stalled;
    logic signed [ACC_W-1:0] hold_d;
    logic [4:0] hold_i;
    int done_c;
    stalled = 1'b0;
    done_c = -1;
    for (int t = 0; t < 300; t++) begin
      if (done) begin
        done_c = cyc;
        break;
      end
      if (stall_at >= 0 && !stalled && out_valid && out_idx == 5'(stall_at)) begin
        out_ready = 1'b0; stalled = 1'b1;
        hold_d = out_data; hold_i = out_idx;
        check({tag, "_stall_beat_value"}, longint'(hold_d), 15);
        for (int w = 0; w < 5; w++) begin
          @(negedge clk);
          check({tag, "_hold_valid"}, longint'(out_valid), 1);
          check({tag, "_hold_data"}, longint'(out_data), longint'(hold_d));
          check({tag, "_hold_idx"}, longint'(out_idx), longint'(hold_i));
        end
        out_ready = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (done_c < 0) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      check({tag, "_done_latency"}, done_c - s - 1, exp_lat);
      check({tag, "_first_valid_latency"}, first_valid_cyc - s - 1, TAPS + 2);
      check({tag, "_busy_with_done"}, longint'(busy), 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, longint'(done), 0);
      check({tag, "_busy_fall"}, longint'(busy), 0);
    end
    check({tag, "_beats"}, beats, exp_n);
    check({tag, "_first_data"}, first_data, exp_first);
    check({tag, "_last_data"}, last_data, exp_last);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_out_data"}, longint'(out_data), 0);
    check({tag, "_out_idx"}, longint'(out_idx), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_state"}, longint'(fsm_state), longint'(IDLE));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit ramp; int val; int k0; int k1; int k2; bit pad; int stall_at;
    int exp_first; int exp_last; int exp_n; string name;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int s;
    int relu_first;
`ifdef CONV_RELU_EN
    relu_first = 0;
`else
    relu_first = -1;
`endif
    vecs[0] = '{0, 10,  -1,   2,  -1, 0, -1, 0,     0,     30, "flat_edge"};
    vecs[1] = '{1, 0,    1,   1,   1, 0, -1, 3,     90,    30, "ramp_box"};
    vecs[2] = '{1, 0,   -1,   2,  -1, 1, -1, relu_first, 32, 32, "ramp_edge_pad"};
    vecs[3] = '{0, 255, 127, 127, 127, 0, -1, 97155, 97155, 30, "max_value"};
    vecs[4] = '{1, 0,    1,   1,   1, 0,  4, 3,     90,    30, "backpressure"};

    #1;
    check_reset_values("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      start_row(make_row(vecs[v].ramp, vecs[v].val), vecs[v].k0, vecs[v].k1, vecs[v].k2,
                vecs[v].pad, 1'b1, s);
      wait_row(s, vecs[v].exp_n + TAPS + 2 + (vecs[v].stall_at >= 0 ? 5 : 0), vecs[v].stall_at,
               vecs[v].exp_first, vecs[v].exp_last, vecs[v].exp_n, vecs[v].name);
    end

    // Reset in the middle of a row.
    start_row(make_row(1'b1, 0), 1, 1, 1, 1'b0, 1'b1, s);
    for (int t = 0; t < 100 && !(out_valid && out_idx == 5'd10); t++) @(negedge clk);
    check("midrow_reached_beat10", longint'(out_idx), 10);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrow_reset");
    exp_q.delete();
    exp_idx_q.delete();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("midrow_no_done", longint'(done), 0);
    end
    rst_n = 1'b1;

    // Kernel cleared by reset: a row without reload produces zeros.
    start_row(make_row(1'b1, 0), 0, 0, 0, 1'b0, 1'b0, s);
    wait_row(s, 30 + TAPS + 2, -1, 0, 0, 30, "cleared_kernel");

    // Reload and run cleanly.
    start_row(make_row(1'b1, 0), 1, 1, 1, 1'b0, 1'b1, s);
    wait_row(s, 30 + TAPS + 2, -1, 3, 90, 30, "after_reset");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
